load_store_unit: RTL

- Multi-cycle load/store unit of the RV32I core.
- Accepts one memory instruction at a time from execute.
- Drives a word-addressed data-memory request/grant/response interface.
- For loads, produces the aligned and extended result on a single-cycle register-file write port (rf_we / rf_wr_addr / rf_wr_din) that feeds the register file write port directly.

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/load_store_unit_load_extend.sv | 33 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and the request legality check.
package rv32i_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

    // A request is rejected when its funct3 is not a valid load/store
    // encoding or when the byte offset does not match the access size.
    function automatic logic lsu_req_bad(input logic       is_load,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        if (is_load) begin
            illegal = !((funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (funct3 == F3_BU) || (funct3 == F3_HU));
        end else begin
            illegal = (funct3 > F3_W);
        end
        case (funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load data alignment: picks the addressed byte or halfword
// out of the read word and sign- or zero-extends it according to funct3.
module load_extend
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by byte offset, then extension by access type.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit. One access in flight at a time;
// drives a word-addressed request/grant/response memory port and writes
// load results through a registered single-cycle register-file port.
//
// Handshakes: execute -> unit transfers when req_valid && req_ready at a
// rising edge (req_ready is high only in IDLE). Unit -> memory holds
// mem_req and all mem_* outputs constant until the edge where mem_gnt is
// seen; the read word is taken on the first edge in WAIT with mem_rvalid.
module load_store_unit
    import rv32i_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [REG_AW-1:0] req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [XLEN-1:0]   rf_wr_din,
    output logic              busy,
    output logic              misalign_err
);

    lsu_state_t        state;
    lsu_state_t        state_d;
    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [REG_AW-1:0] rd_q;

    logic              accept;
    logic              req_bad;
    logic              start;
    logic [3:0]        wstrb_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   load_result;

    assign accept    = (state == IDLE) && req_valid;
    assign req_bad   = lsu_req_bad(req_is_load, req_funct3, req_addr[1:0]);
    assign start     = accept && !req_bad;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    // FSM state register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state logic: stores finish on grant, loads wait for read data.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (mem_gnt) state_d = is_load_q ? WAIT : IDLE;
            WAIT:    if (mem_rvalid) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store lane steering from the incoming request; loads write no bytes.
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = req_wdata;
        if (!req_is_load) begin
            case (req_funct3)
                F3_B: begin
                    wstrb_d = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: wstrb_d = 4'b1111;
            endcase
        end
    end

    // Registered request capture, memory outputs and register-file port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            rd_q         <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= 4'b0000;
            mem_wdata    <= '0;
            rf_we        <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_din    <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= accept && req_bad;
            if (start) begin
                is_load_q <= req_is_load;
                funct3_q  <= req_funct3;
                offset_q  <= req_addr[1:0];
                rd_q      <= req_rd;
                mem_req   <= 1'b1;
                mem_we    <= !req_is_load;
                mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                mem_wstrb <= wstrb_d;
                mem_wdata <= wdata_d;
            end else if ((state == REQ) && mem_gnt) begin
                mem_req <= 1'b0;
            end
            rf_we <= 1'b0;
            if ((state == WAIT) && mem_rvalid) begin
                rf_we      <= (rd_q != '0);
                rf_wr_addr <= rd_q;
                rf_wr_din  <= load_result;
            end
        end
    end

endmodule
